// File: rtl/ram_fifo_ctrl_if.sv
// ---------------------------------------------------------------------------
// ram_fifo_ctrl_if : producer/consumer streams and external RAM port bundle
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface ram_fifo_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             ram_wr_en;
  logic [AW-1:0]    ram_wr_addr;
  logic [WIDTH-1:0] ram_din;
  logic [AW-1:0]    ram_rd_addr;
  logic [WIDTH-1:0] ram_dout;
  logic [AW+1:0]    count;

  // Controller side
  modport slave (
    input  s_valid, s_data, m_ready, ram_dout,
    output s_ready, m_valid, m_data, ram_wr_en, ram_wr_addr, ram_din,
           ram_rd_addr, count
  );

  // Parent / environment side
  modport master (
    output s_valid, s_data, m_ready, ram_dout,
    input  s_ready, m_valid, m_data, ram_wr_en, ram_wr_addr, ram_din,
           ram_rd_addr, count
  );
endinterface

`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ram_fifo_ctrl : FIFO controller for an external 1-cycle-read dual-port RAM
// Optional almost_full output enabled by macro RAM_FIFO_CTRL_ALMOST_FULL_EN.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ram_fifo_ctrl #(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = DEPTH - 2
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  ram_fifo_ctrl_if.slave if_bus
`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
  ,
  output logic           almost_full
`endif
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;
  logic             r_pending;
  logic [1:0]       r_q_cnt;
  logic [WIDTH-1:0] r_q0;
  logic [WIDTH-1:0] r_q1;
  logic [AW+1:0]    r_count;

  logic [AW:0]      w_occ;
  logic [AW:0]      w_occ_nxt;
  logic             w_full;
  logic             w_empty;
  logic             w_m_valid;
  logic             w_push;
  logic             w_pop;
  logic             w_fetch;
  logic [2:0]       w_q_need;

  assign w_occ     = r_wp - r_rp;
  assign w_full    = (w_occ == C_DEPTH);
  assign w_empty   = (r_wp == r_rp);
  assign w_m_valid = (r_q_cnt != 2'd0);
  assign w_push    = if_bus.s_valid & ~w_full;
  assign w_pop     = w_m_valid & if_bus.m_ready;

  // Words that will occupy the queue after this edge, before any new fetch
  assign w_q_need  = {1'b0, r_q_cnt} + {2'b00, r_pending} - {2'b00, w_pop};
  assign w_fetch   = ~w_empty & (w_q_need < 3'd2);
  assign w_occ_nxt = w_occ + (AW+1)'(w_push) - (AW+1)'(w_fetch);

  assign if_bus.s_ready     = ~w_full;
  assign if_bus.ram_wr_en   = w_push;
  assign if_bus.ram_wr_addr = r_wp[AW-1:0];
  assign if_bus.ram_din     = if_bus.s_data;
  assign if_bus.ram_rd_addr = r_rp[AW-1:0];
  assign if_bus.m_valid     = w_m_valid;
  assign if_bus.m_data      = r_q0;
  assign if_bus.count       = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_pending <= 1'b0;
      r_q_cnt   <= 2'd0;
      r_count   <= '0;
    end else begin
      if (w_push)  r_wp <= r_wp + 1'b1;
      if (w_fetch) r_rp <= r_rp + 1'b1;
      r_pending <= w_fetch;
      r_q_cnt   <= w_q_need[1:0];
      r_count   <= (AW+2)'(w_occ_nxt) + (AW+2)'(w_fetch) + (AW+2)'(w_q_need);
    end
  end

  // q0 is always the head; a load lands behind whatever survives the pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q0 <= '0;
      r_q1 <= '0;
    end else if (r_pending && w_pop) begin
      if (r_q_cnt == 2'd2) begin
        r_q0 <= r_q1;
        r_q1 <= if_bus.ram_dout;
      end else begin
        r_q0 <= if_bus.ram_dout;
      end
    end else if (r_pending) begin
      if (r_q_cnt == 2'd0) r_q0 <= if_bus.ram_dout;
      else                 r_q1 <= if_bus.ram_dout;
    end else if (w_pop) begin
      r_q0 <= r_q1;
    end
  end

`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
  logic r_afull;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_afull <= 1'b0;
    else        r_afull <= (32'(w_occ_nxt) >= AFULL_LEVEL);
  end

  assign almost_full = r_afull;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_fifo_ctrl : directed self-checking bench with a behavioural RAM
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ram_fifo_ctrl;
  localparam int WIDTH = 4;
  localparam int DEPTH = 8;

  logic clk;
  logic rst_n;
  logic af;
  int   n_cmp;
  int   n_fail;
  logic [WIDTH-1:0] exp_q [0:22];
  logic [WIDTH-1:0] mem   [0:DEPTH-1];

  ram_fifo_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_if ();

  ram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_bus     (bus_if.slave)
`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
    ,
    .almost_full(af)
`endif
  );

`ifndef RAM_FIFO_CTRL_ALMOST_FULL_EN
  assign af = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sibling RAM: synchronous write, registered read
  always @(posedge clk) begin
    if (bus_if.ram_wr_en) mem[bus_if.ram_wr_addr] <= bus_if.ram_din;
    bus_if.ram_dout <= mem[bus_if.ram_rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus_if.s_valid = 1'b0;
    bus_if.s_data  = '0;
    bus_if.m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    bus_if.ram_dout = '0;

    // Reset state
    tick(); tick();
    #1;
    chk("rst_count", 32'(bus_if.count), 0);
    chk("rst_mvalid", 32'(bus_if.m_valid), 0);
    chk("rst_mdata", 32'(bus_if.m_data), 0);
    chk("rst_sready", 32'(bus_if.s_ready), 1);
`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
    chk("rst_afull", 32'(af), 0);
`endif
    rst_n = 1'b1;

    // Single word latency
    tick();
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = 4'h3;
    bus_if.m_ready = 1'b1;
    #1;
    chk("t1_wr_en", 32'(bus_if.ram_wr_en), 1);
    chk("t1_wr_addr", 32'(bus_if.ram_wr_addr), 0);
    chk("t1_din", 32'(bus_if.ram_din), 3);
    tick();
    bus_if.s_valid = 1'b0;
    #1;
    chk("t1_c1_mvalid", 32'(bus_if.m_valid), 0);
    chk("t1_c1_count", 32'(bus_if.count), 1);
    chk("t1_c1_rd_addr", 32'(bus_if.ram_rd_addr), 0);
    tick(); #1;
    chk("t1_c2_mvalid", 32'(bus_if.m_valid), 0);
    tick(); #1;
    chk("t1_c3_mvalid", 32'(bus_if.m_valid), 1);
    chk("t1_c3_mdata", 32'(bus_if.m_data), 3);
    chk("t1_c3_count", 32'(bus_if.count), 1);
    tick(); #1;
    chk("t1_c4_mvalid", 32'(bus_if.m_valid), 0);
    chk("t1_c4_count", 32'(bus_if.count), 0);

    // Fill: 8 words in RAM plus 2 in the queue
    bus_if.m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus_if.s_valid = 1'b1;
      bus_if.s_data  = 4'(i);
      #1;
      chk("fill_sready", 32'(bus_if.s_ready), 1);
`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
      chk("fill_afull", 32'(af), (i >= 8) ? 1 : 0);
`endif
      tick();
    end
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = 4'hA;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full_sready", 32'(bus_if.s_ready), 0);
      chk("full_wr_en", 32'(bus_if.ram_wr_en), 0);
      chk("full_count", 32'(bus_if.count), 10);
      chk("full_mdata", 32'(bus_if.m_data), 0);
      tick();
    end
    bus_if.s_valid = 1'b0;

    // Drain back-to-back
    bus_if.m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("drain_mvalid", 32'(bus_if.m_valid), 1);
      chk("drain_mdata", 32'(bus_if.m_data), 32'(i));
      if (i == 0) chk("drain_sready0", 32'(bus_if.s_ready), 0);
      if (i == 1) chk("drain_sready1", 32'(bus_if.s_ready), 1);
`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
      chk("drain_afull", 32'(af), (i < 3) ? 1 : 0);
`endif
      tick();
    end
    #1;
    chk("drain_end_mvalid", 32'(bus_if.m_valid), 0);
    chk("drain_end_count", 32'(bus_if.count), 0);

    // Streaming across the pointer wrap
    tick();
    for (int j = 0; j < 23; j++) begin
      exp_q[j] = 4'(j + 5);
      bus_if.s_valid = (j < 20);
      bus_if.s_data  = exp_q[j];
      #1;
      if (j < 3) begin
        chk("strm_mvalid_lo", 32'(bus_if.m_valid), 0);
      end else begin
        chk("strm_mvalid", 32'(bus_if.m_valid), 1);
        chk("strm_mdata", 32'(bus_if.m_data), 32'(exp_q[j-3]));
      end
      if (j >= 3 && j < 20) chk("strm_count", 32'(bus_if.count), 3);
      tick();
    end
    bus_if.s_valid = 1'b0;
    #1;
    chk("strm_end_count", 32'(bus_if.count), 0);
    chk("strm_end_mvalid", 32'(bus_if.m_valid), 0);

    // Asynchronous reset with words held
    bus_if.m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      bus_if.s_valid = 1'b1;
      bus_if.s_data  = 4'(i);
      tick();
    end
    bus_if.s_valid = 1'b0;
    tick(); tick(); tick();
    #1;
    chk("pre_rst_count", 32'(bus_if.count), 5);
    chk("pre_rst_mvalid", 32'(bus_if.m_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_mvalid", 32'(bus_if.m_valid), 0);
    chk("arst_count", 32'(bus_if.count), 0);
    chk("arst_sready", 32'(bus_if.s_ready), 1);
    #1;
    rst_n = 1'b1;
    tick();
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = 4'hA;
    bus_if.m_ready = 1'b1;
    #1;
    chk("post_rst_wr_addr", 32'(bus_if.ram_wr_addr), 0);
    chk("post_rst_wr_en", 32'(bus_if.ram_wr_en), 1);
    tick();
    bus_if.s_valid = 1'b0;
    tick(); tick();
    #1;
    chk("post_rst_mvalid", 32'(bus_if.m_valid), 1);
    chk("post_rst_mdata", 32'(bus_if.m_data), 32'hA);
    tick(); #1;
    chk("post_rst_count", 32'(bus_if.count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
